// File: rtl/mul_div_unit.sv
// Iterative HI/LO unit: shift-add multiplier and restoring divider that own the
// architectural Hi/Lo registers, plus single-edge MTHI/MTLO moves.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000, OP_MULTU = 3'b001, OP_DIV  = 3'b010, OP_DIVU = 3'b011,
        OP_MADD  = 3'b100, OP_MSUB  = 3'b101, OP_MTHI = 3'b110, OP_MTLO = 3'b111
    } op_e;

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_e;

    state_e           state;
    op_e              op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    prod, mcand;
    logic [WIDTH-1:0] mplier, rem, quo;
    logic             neg_prod, neg_rem;

    logic             is_signed;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] rem_next;
    logic [PW-1:0]    mul_res;
    logic [WIDTH-1:0] quo_res, rem_res;

    // Operand magnitudes, one iteration step and the sign-corrected results
    always_comb begin
        is_signed = (op_q == OP_MULT) || (op_q == OP_DIV) ||
                    (op_q == OP_MADD) || (op_q == OP_MSUB);
        a_mag     = (is_signed && a_q[WIDTH-1]) ? WIDTH'(-a_q) : a_q;
        b_mag     = (is_signed && b_q[WIDTH-1]) ? WIDTH'(-b_q) : b_q;
        div_trial = {rem, quo[WIDTH-1]};
        div_ge    = (div_trial >= {1'b0, b_q});
        rem_next  = div_ge ? WIDTH'(div_trial - {1'b0, b_q}) : div_trial[WIDTH-1:0];
        mul_res   = neg_prod ? PW'(-prod) : prod;
        quo_res   = neg_prod ? WIDTH'(-quo) : quo;
        rem_res   = neg_rem ? WIDTH'(-rem) : rem;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state    <= S_IDLE;
            op_q     <= OP_MULT;
            a_q      <= '0;
            b_q      <= '0;
            cnt      <= '0;
            prod     <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            quo      <= '0;
            neg_prod <= 1'b0;
            neg_rem  <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            DivZero  <= 1'b0;
            Hi       <= '0;
            Lo       <= '0;
        end else begin
            Done <= 1'b0;
            if (state == S_IDLE) begin
                if (Start && !Flush) begin
                    if (op_e'(Op) == OP_MTHI) begin
                        Hi <= A;
                    end else if (op_e'(Op) == OP_MTLO) begin
                        Lo <= A;
                    end else begin
                        op_q  <= op_e'(Op);
                        a_q   <= A;
                        b_q   <= B;
                        state <= S_PREP;
                        Busy  <= 1'b1;
                    end
                end
            end else if (Flush) begin
                state <= S_IDLE;
                Busy  <= 1'b0;
            end else begin
                case (state)
                    S_PREP: begin
                        // b_q becomes the divisor magnitude; a_q stays raw for the div-by-zero Hi
                        b_q      <= b_mag;
                        mcand    <= PW'(a_mag);
                        mplier   <= b_mag;
                        prod     <= '0;
                        rem      <= '0;
                        quo      <= a_mag;
                        neg_prod <= is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                        neg_rem  <= is_signed && a_q[WIDTH-1];
                        cnt      <= '0;
                        state    <= S_ITER;
                    end
                    S_ITER: begin
                        if (mplier[0]) begin
                            prod <= prod + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        rem    <= rem_next;
                        quo    <= {quo[WIDTH-2:0], div_ge};
                        cnt    <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) begin
                            state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        case (op_q)
                            OP_MADD: {Hi, Lo} <= {Hi, Lo} + mul_res;
                            OP_MSUB: {Hi, Lo} <= {Hi, Lo} - mul_res;
                            OP_DIV, OP_DIVU: begin
                                if (b_q == '0) begin
                                    Lo      <= '1;
                                    Hi      <= a_q;
                                    DivZero <= 1'b1;
                                end else begin
                                    Lo      <= quo_res;
                                    Hi      <= rem_res;
                                    DivZero <= 1'b0;
                                end
                            end
                            default: {Hi, Lo} <= mul_res;
                        endcase
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: cycle-level arithmetic model compared every cycle,
// directed literal cases, then randomized ops with spurious starts and flushes.
module tb_mul_div_unit;
    localparam int unsigned W   = 32;
    localparam int unsigned LAT = W + 2;

    logic          Clk = 1'b0;
    logic          Reset, Start, Flush;
    logic [2:0]    Op;
    logic [W-1:0]  A, B;
    logic          Busy, Done, DivZero;
    logic [W-1:0]  Hi, Lo;

    int n_cmp = 0;
    int n_err = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .Flush(Flush), .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clk = ~Clk;

    // Model state: architectural results plus a simple latency countdown
    logic         m_valid = 1'b0;
    logic         m_busy, m_done, m_dz;
    logic [W-1:0] m_hi, m_lo;
    int           m_left;
    logic [2:0]   p_op;
    logic [W-1:0] p_a, p_b;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge Clk) begin
        longint      sa, sb;
        logic [63:0] acc;
        m_done = 1'b0;
        if (!Reset) begin
            m_valid = 1'b1;
            m_busy = 1'b0; m_dz = 1'b0; m_hi = '0; m_lo = '0; m_left = 0;
        end else if (m_valid && m_busy) begin
            if (Flush) begin
                m_busy = 1'b0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    sa = $signed(p_a);
                    sb = $signed(p_b);
                    acc = {m_hi, m_lo};
                    case (p_op)
                        3'b000: acc = 64'(sa * sb);
                        3'b001: acc = {32'd0, p_a} * {32'd0, p_b};
                        3'b100: acc = acc + 64'(sa * sb);
                        3'b101: acc = acc - 64'(sa * sb);
                        default: begin
                            if (p_b == '0) begin
                                acc = {p_a, 32'hFFFF_FFFF};
                                m_dz = 1'b1;
                            end else begin
                                m_dz = 1'b0;
                                if (p_op == 3'b010)
                                    acc = {32'(sa % sb), 32'(sa / sb)};
                                else
                                    acc = {p_a % p_b, p_a / p_b};
                            end
                        end
                    endcase
                    {m_hi, m_lo} = acc;
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end
        end else if (m_valid && Start && !Flush) begin
            if (Op == 3'b110) m_hi = A;
            else if (Op == 3'b111) m_lo = A;
            else begin
                p_op = Op; p_a = A; p_b = B;
                m_busy = 1'b1;
                m_left = LAT;
            end
        end
    end

    always @(negedge Clk) begin
        if (m_valid) begin
            chk("busy", 64'(Busy), 64'(m_busy));
            chk("done", 64'(Done), 64'(m_done));
            chk("divzero", 64'(DivZero), 64'(m_dz));
            chk("hi", 64'(Hi), 64'(m_hi));
            chk("lo", 64'(Lo), 64'(m_lo));
        end
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int t = 0;
        while (Busy && t < 200) begin
            @(negedge Clk);
            t++;
        end
        if (Busy) chk("issue_wait_idle", 64'(Busy), 64'd0);
        Start = 1'b1; Op = op; A = a; B = b;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_done(output int nbusy);
        int t = 0;
        nbusy = 0;
        while (!Done && t < 200) begin
            if (Busy) nbusy++;
            @(negedge Clk);
            t++;
        end
        chk("done_seen", 64'(Done), 64'd1);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int nb;
        issue(op, a, b);
        wait_done(nb);
        chk({name, "_busy_cycles"}, 64'(nb), 64'(LAT));
        chk({name, "_hi"}, 64'(Hi), 64'(ehi));
        chk({name, "_lo"}, 64'(Lo), 64'(elo));
        chk({name, "_model"}, {m_hi, m_lo}, {ehi, elo});
    endtask

    task automatic rand_op();
        logic [W-1:0] a, b;
        int mode, fl_at;
        a = $urandom();
        b = $urandom();
        case ($urandom_range(0, 5))
            0: b = '0;
            1: begin a = 32'h8000_0000; b = '1; end
            2: b = 32'($urandom_range(1, 9));
            default: ;
        endcase
        mode  = $urandom_range(0, 3);
        fl_at = $urandom_range(0, LAT);
        issue(3'($urandom_range(0, 7)), a, b);
        for (int k = 0; k < LAT + 2; k++) begin
            Start = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            Op    = 3'($urandom_range(0, 7));
            A     = $urandom();
            B     = $urandom();
            Flush = (mode == 2 && k == fl_at) || (mode == 3 && $urandom_range(0, 30) == 0);
            @(negedge Clk);
        end
        Start = 1'b0;
        Flush = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        Reset = 1'b0; Start = 1'b0; Flush = 1'b0; Op = '0; A = '0; B = '0;
        repeat (2) @(negedge Clk);
        chk("reset_hi", 64'(Hi), 64'd0);
        chk("reset_lo", 64'(Lo), 64'd0);
        chk("reset_busy", 64'(Busy), 64'd0);
        Reset = 1'b1;

        issue(3'b110, 32'h1234_5678, '0);
        chk("mthi_hi", 64'(Hi), 64'h1234_5678);
        chk("mthi_busy_done", 64'({Busy, Done}), 64'd0);
        issue(3'b111, 32'h9ABC_DEF0, '0);
        chk("mtlo_lo", 64'(Lo), 64'h9ABC_DEF0);
        chk("mtlo_hi", 64'(Hi), 64'h1234_5678);

        run_op("mult",  3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu", 3'b001, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB);

        issue(3'b110, 32'h0, '0);
        issue(3'b111, 32'hFFFF_FFFF, '0);
        run_op("madd", 3'b100, 32'd1, 32'd1, 32'd1, 32'd0);
        run_op("msub", 3'b101, 32'd2, 32'd1, 32'd0, 32'hFFFF_FFFE);

        run_op("div_neg",   3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_minm1", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_op("divu_zero", 3'b011, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        chk("divu_zero_flag", 64'(DivZero), 64'd1);
        run_op("divu_9_3",  3'b011, 32'd9, 32'd3, 32'd0, 32'd3);
        chk("divu_9_3_flag", 64'(DivZero), 64'd0);

        // Flush mid-divide: no write, no Done
        issue(3'b010, 32'd100, 32'd7);
        repeat (10) @(negedge Clk);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        chk("flush_busy", 64'(Busy), 64'd0);
        chk("flush_hilo", {Hi, Lo}, {32'd0, 32'd3});
        repeat (LAT) @(negedge Clk);
        chk("flush_no_done_hilo", {Hi, Lo}, {32'd0, 32'd3});

        // Start held through Busy with other operands must be ignored
        issue(3'b011, 32'd20, 32'd3);
        Start = 1'b1; Op = 3'b000; A = 32'd99; B = 32'd1;
        repeat (10) @(negedge Clk);
        Start = 1'b0;
        wait_done(nb);
        chk("ignore_start_hilo", {Hi, Lo}, {32'd2, 32'd6});

        // Reset in the middle of a multiply
        issue(3'b000, 32'd1234, 32'd5678);
        repeat (19) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        chk("midreset_hilo", {Hi, Lo}, 64'd0);
        chk("midreset_busy", 64'(Busy), 64'd0);
        run_op("multu_5x5", 3'b001, 32'd5, 32'd5, 32'd0, 32'd25);

        for (int i = 0; i < 80; i++) rand_op();
        repeat (LAT + 4) @(negedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised multi-cycle HI/LO arithmetic unit for the MIPS datapath: multiply, multiply-accumulate, multiply-subtract and divide, plus direct HI/LO moves.
- Replaces the single-cycle combinational HI/LO path in the ALU with an iterative shift-add multiplier and a restoring divider that own the architectural Hi/Lo registers.
- Sits beside the ALU in EX. The hazard unit stalls on Busy, and mfhi/mflo read Hi/Lo directly.

Parameters:
- WIDTH, 32, operand width and width of each of Hi and Lo; 2*WIDTH product/accumulator.

Ports:
- Clk  input  1  clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-low reset.
- Start  input  1  request; accepted only when Busy=0.
- Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB, 110 MTHI, 111 MTLO.
- A  input  WIDTH  rs operand (dividend / multiplicand / move source).
- B  input  WIDTH  rt operand (divisor / multiplier).
- Flush  input  1  abort in-flight operation (branch squash).
- Busy  output  1  operation in flight; Start ignored.
- Done  output  1  one-cycle pulse when Hi/Lo updated by an iterative op.
- DivZero  output  1  sticky for the last DIV/DIVU: divisor was 0.
- Hi  output  WIDTH  architectural HI.
- Lo  output  WIDTH  architectural LO.

Behaviour:
- Reset (Reset=0 at an edge):
  - Hi=0, Lo=0, Busy=0, Done=0, DivZero=0, state=IDLE.
  - Overrides Start/Flush and aborts any op in flight.
- States: IDLE -> PREP -> ITER -> FIX -> IDLE.
- IDLE, Start=1, Op=MTHI/MTLO:
  - Hi (or Lo) <= A at that edge.
  - Busy stays 0, Done stays 0, no state change.
- IDLE, Start=1, Op in 000-101: latch A, B, Op; go to PREP; Busy=1 from next cycle.
- PREP (1 cycle):
  - Signed ops (MULT, DIV, MADD, MSUB): take magnitudes and record result sign(s).
  - Unsigned ops use operands as-is.
  - Clear the iteration counter.
- ITER (exactly WIDTH cycles, counter 0..WIDTH-1):
  - Multiply: one multiplier bit per cycle, shift-add into a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle, WIDTH+1-bit partial remainder.
- FIX (1 cycle):
  - Apply sign correction.
  - MADD/MSUB: {Hi,Lo} <= {Hi,Lo} ± signed product, modulo 2^(2*WIDTH).
  - MULT/MULTU: {Hi,Lo} <= product.
  - DIV/DIVU: Lo <= quotient, Hi <= remainder.
  - Update Hi/Lo, assert Done, go to IDLE; Busy=0 in the cycle Done is high.
- Latency: accept edge to Done-high edge = WIDTH+2 cycles (34 for WIDTH=32). Throughput: one op per WIDTH+3 cycles (Start may be asserted while Done=1).
- Signed divide:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - MIN/-1 yields Lo=MIN, Hi=0.
- Divide by zero (B=0, DIV/DIVU):
  - Full latency still taken.
  - Lo <= all ones, Hi <= A.
  - DivZero <= 1 at the FIX edge.
  - DivZero is cleared at the FIX edge of the next DIV/DIVU with B≠0; multiplies leave it unchanged.
- Start while Busy=1: ignored, no queueing; the requester must hold Start until Busy=0.
- Flush while Busy=1:
  - Return to IDLE next edge; Busy=0, Hi/Lo unchanged, no Done.
  - Flush on the FIX edge beats the write.
- Flush with Start in IDLE: Start ignored that cycle.
- Flush in IDLE with no Start: no effect.
- Operands are sampled only at the accept edge; A/B changes during Busy have no effect.
- Done is never asserted for MTHI/MTLO or after Flush/Reset.

Test Plan:
- Reset=0 for 2 cycles, then MTHI A=32'h1234_5678 followed by MTLO A=32'h9ABC_DEF0 -> Hi=32'h1234_5678, Lo=32'h9ABC_DEF0 immediately after each accept edge; Busy and Done stay 0.
- MULT A=-3 (32'hFFFF_FFFD), B=7 -> Busy for 34 cycles; Done pulses once; Hi=32'hFFFF_FFFF, Lo=32'hFFFF_FFEB. MULTU with the same operands -> Hi=32'h0000_0006, Lo=32'hFFFF_FFEB.
- Starting from Hi=0, Lo=32'hFFFF_FFFF, MADD A=1, B=1 -> Hi=1, Lo=0 (carry across halves). Then MSUB A=2, B=1 -> Hi=0, Lo=32'hFFFF_FFFE.
- DIV A=-7, B=2 -> Lo=-3, Hi=-1. DIV A=32'h8000_0000, B=-1 -> Lo=32'h8000_0000, Hi=0. DIVU A=7, B=0 -> Lo=32'hFFFF_FFFF, Hi=7, DivZero=1. A following DIVU 9/3 -> Lo=3, Hi=0, DivZero=0.
- Start DIV, assert Flush at ITER cycle 10 -> Busy drops next edge; Hi/Lo keep prior values; no Done. A second Start issued during Busy must be ignored, checked by comparing results against a single-op model.
- Reset=0 mid-MULT (cycle 20) -> Hi=Lo=0, Busy=0 next edge; a new MULTU 5*5 afterwards gives Lo=25, Hi=0 with normal latency.
